// File: rtl/contador_palabras.sv
// Word counters for output FIFOs 4..7 with a one-cycle registered read port.
// Each lane counts valid pops (pop & ~empty); reads are accepted only while IDLE.

module contador_palabras_lane #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             pop,
  input  logic             empty,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vpop;

  assign vpop = pop & ~empty;

  // init beats everything; a clear with a same-cycle pop leaves 1, not 0
  always_comb begin
    cnt_d = cnt_q;
    if (init)
      cnt_d = '0;
    else if (clr)
      cnt_d = vpop ? CNT_W'(1) : '0;
    else if (vpop)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module contador_palabras #(
  parameter int CNT_W       = 5,
  parameter int CLR_ON_READ = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             pop4,
  input  logic             pop5,
  input  logic             pop6,
  input  logic             pop7,
  input  logic             empty4,
  input  logic             empty5,
  input  logic             empty6,
  input  logic             empty7,
  input  logic             req,
  input  logic [1:0]       idx,
  input  logic             IDLE,
  output logic             valid_contador,
  output logic [CNT_W-1:0] contador_out
);
  typedef enum logic {WAIT = 1'b0, RESP = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       out_q, out_d;
  logic [3:0]             pop_v, empty_v, clr;
  logic [3:0][CNT_W-1:0]  cnt;
  logic                   accept;

  assign pop_v   = {pop7, pop6, pop5, pop4};
  assign empty_v = {empty7, empty6, empty5, empty4};
  assign accept  = req & IDLE;

  always_comb begin
    clr = '0;
    if (CLR_ON_READ != 0 && accept) clr[idx] = 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    contador_palabras_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .init  (init),
      .pop   (pop_v[g]),
      .empty (empty_v[g]),
      .clr   (clr[g]),
      .cnt   (cnt[g])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= WAIT;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    state_d = accept ? RESP : WAIT;
      RESP:    state_d = accept ? RESP : WAIT;
      default: state_d = WAIT;
    endcase
  end

  // Pre-edge count is returned; a read taken while init is high reports the cleared value
  always_comb begin
    valid_contador = (state_q == RESP);
    out_d          = (accept && !init) ? cnt[idx] : '0;
  end

  assign contador_out = out_q;
endmodule

// File: tb/tb_contador_palabras.sv
// Directed bench for contador_palabras; a second instance runs with clear-on-read.
`timescale 1ns/1ps
module tb_contador_palabras;
  logic       clk = 1'b0;
  logic       reset, init, req, IDLE;
  logic [3:0] pop, empty;
  logic [1:0] idx;
  logic       valid_a, valid_b;
  logic [4:0] out_a, out_b;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  contador_palabras #(.CNT_W(5), .CLR_ON_READ(0)) dut (
    .clk(clk), .reset(reset), .init(init),
    .pop4(pop[0]), .pop5(pop[1]), .pop6(pop[2]), .pop7(pop[3]),
    .empty4(empty[0]), .empty5(empty[1]), .empty6(empty[2]), .empty7(empty[3]),
    .req(req), .idx(idx), .IDLE(IDLE),
    .valid_contador(valid_a), .contador_out(out_a)
  );

  contador_palabras #(.CNT_W(5), .CLR_ON_READ(1)) dut_clr (
    .clk(clk), .reset(reset), .init(init),
    .pop4(pop[0]), .pop5(pop[1]), .pop6(pop[2]), .pop7(pop[3]),
    .empty4(empty[0]), .empty5(empty[1]), .empty6(empty[2]), .empty7(empty[3]),
    .req(req), .idx(idx), .IDLE(IDLE),
    .valid_contador(valid_b), .contador_out(out_b)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; req = 1'b0; IDLE = 1'b1;
    pop = '0; empty = '0; idx = '0;
    tick(2);
    chk("rst_valid", valid_a, 0);
    chk("rst_out", out_a, 0);
    reset = 1'b0;

    // T1: cnt[1]=7, response in flight, then reset mid-cycle
    pop = 4'b0010;
    tick(7);
    pop = '0; req = 1'b1; idx = 2'd1;
    tick();
    chk("t1_valid_pre", valid_a, 1);
    chk("t1_out_pre", out_a, 7);
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t1_async_valid", valid_a, 0);
    chk("t1_async_out", out_a, 0);
    tick();
    reset = 1'b0;
    req = 1'b1; idx = 2'd1;
    tick();
    chk("t1_read_valid", valid_a, 1);
    chk("t1_read_out", out_a, 0);
    req = 1'b0;
    tick();
    chk("t1_back_wait_valid", valid_a, 0);
    chk("t1_back_wait_out", out_a, 0);

    // T2: six pops each, then four back-to-back reads
    pop = 4'hF;
    tick(6);
    pop = '0; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(i);
      tick();
      chk($sformatf("t2_valid%0d", i), valid_a, 1);
      chk($sformatf("t2_out%0d", i), out_a, 6);
    end
    req = 1'b0;
    tick();
    chk("t2_end_valid", valid_a, 0);

    // T3: pops on an empty FIFO are ignored; req outside IDLE is ignored
    pop = 4'b0010; empty = 4'b0010;
    tick(3);
    pop = '0; empty = '0;
    req = 1'b1; IDLE = 1'b0; idx = 2'd1;
    tick();
    chk("t3_noidle_valid0", valid_a, 0);
    tick();
    chk("t3_noidle_valid1", valid_a, 0);
    IDLE = 1'b1;
    tick();
    chk("t3_cnt1_valid", valid_a, 1);
    chk("t3_cnt1_out", out_a, 6);
    req = 1'b0;

    // T4: read during init reports 0; 33 pops wrap to 1; init drops a same-cycle pop
    init = 1'b1; req = 1'b1; idx = 2'd0;
    tick();
    chk("t4_init_read_valid", valid_a, 1);
    chk("t4_init_read_out", out_a, 0);
    init = 1'b0; req = 1'b0;
    pop = 4'b0100;
    tick(33);
    pop = '0; req = 1'b1; idx = 2'd2;
    tick();
    chk("t4_wrap_out", out_a, 1);
    req = 1'b0;
    init = 1'b1; pop = 4'b1000;
    tick();
    init = 1'b0; pop = '0;
    req = 1'b1; idx = 2'd3;
    tick();
    chk("t4_init_pop_out", out_a, 0);
    chk("t4_init_pop_out_clr", out_b, 0);
    req = 1'b0;
    tick();

    // T5: read with a same-cycle pop returns the pre-edge count
    pop = 4'b1000;
    tick(4);
    req = 1'b1; idx = 2'd3;
    tick();
    chk("t5_first_out", out_a, 4);
    chk("t5_first_out_clr", out_b, 4);
    pop = '0;
    tick();
    chk("t5_second_valid", valid_a, 1);
    chk("t5_second_out", out_a, 5);
    chk("t5_second_out_clr", out_b, 1);
    req = 1'b0; idx = 2'd0;
    #3;
    chk("t5_hold_out", out_a, 5);
    tick();

    // T6: four words through each FIFO, then a drained pop that must not count
    pop = 4'hF;
    tick(4);
    empty = 4'hF;
    tick();
    pop = '0; empty = '0; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(i);
      tick();
      chk($sformatf("t6_out%0d", i), out_a, (i == 3) ? 9 : 4);
      chk($sformatf("t6_out_clr%0d", i), out_b, 4);
    end
    req = 1'b0;
    tick();
    chk("t6_end_valid", valid_a, 0);
    chk("t6_end_valid_clr", valid_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
